fp_add_step2_addnorm: RTL and testbench
=======================================

// Module: fp_add_step2_addnorm
// PURPOSE
//  Stage 2 of the pipelined single-precision FP adder; consumes stage-1 buffer outputs (aligned operands).
//  Adds/subtracts the aligned 24-bit mantissas, then normalises iteratively (one left shift/cycle).
//  Truncation rounding. Packs the IEEE-754 result and holds it under a valid/ready handshake.
//  Special operands (exp 0/255) are resolved upstream and are out of scope here.
// PARAMETERS
//  EXP_W  8   exponent width
//  MAN_W  24  mantissa width, hidden bit included (bit MAN_W-1)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous reset, active low
//  in_valid     in   1      operand set valid
//  in_ready     out  1      stage can accept an operand set
//  sign_a1      in   1      sign of A
//  sign_b1      in   1      sign of B
//  s1           in   1      op select: 0 = A+B, 1 = A-B
//  exp_a1       in   EXP_W  common (aligned) exponent; exp_b1 is ignored
//  exp_b1       in   EXP_W  unused, kept for port symmetry with stage 1
//  mantissa_a1  in   MAN_W  aligned mantissa A
//  mantissa_b1  in   MAN_W  aligned mantissa B, already right-shifted
//  out_valid    out  1      result valid
//  out_ready    in   1      downstream accepts result
//  result       out  32     packed {sign, exp[7:0], frac[22:0]}
// BEHAVIOUR
//  FSM states: IDLE, ADD, NORM, DONE. Reset: state=IDLE, in_ready=1, out_valid=0, result=0, internal regs=0.
//  IDLE: in_ready=1. in_valid=1 at an edge -> capture all inputs, go to ADD. in_ready=0 in every other state.
//  ADD: eff_sub = sign_a1^sign_b1^s1. sum is 25 bits.
//   - eff_sub=0: sum = ma+mb, sign = sign_a1.
//   - eff_sub=1 and ma>=mb: sum = ma-mb, sign = sign_a1.
//   - eff_sub=1 and ma<mb: sum = mb-ma, sign = sign_b1^s1.
//   - sum==0 -> result=32'h0 (+0), go to DONE.
//   - sum[24]=1 -> sum>>=1, exp+=1. If exp reaches 255 -> result = {sign, 8'hFF, 23'h0}, go to DONE.
//   - Otherwise, sum[23]=1 -> DONE; else -> NORM.
//  NORM, one action per edge:
//   - sum[23]=1 -> DONE.
//   - sum[23]=0 and exp>1 -> sum<<=1, exp-=1.
//   - exp==1 with sum[23]=0 -> flush to +0 (underflow), go to DONE.
//  DONE: out_valid=1; result = {sign, exp, sum[22:0]}, held stable while out_ready=0.
//   - out_valid & out_ready at an edge -> IDLE (in_ready=1 on the next cycle). No bypass: at most one operation in flight.
//  Latency: accept edge T; out_valid first high after edge T+2 when no left shift is needed, T+2+k for k left shifts (k<=23).
//  rst_n low at any edge, in any state (incl. mid-NORM) -> reset values on that edge; the in-flight operation is discarded.
//  Inputs are ignored outside IDLE. in_valid held high while busy is not consumed until the FSM returns to IDLE.
// CONFIGURATION
//  FPADD_STATUS_EN defined: adds output status[2:0] = {overflow, underflow, zero}.
//   - status is registered together with result, valid only while out_valid=1, reset to 0.
//   - overflow: exp saturated to 255. underflow: flushed in NORM. zero: exact cancellation or flush.
//  FPADD_STATUS_EN undefined: no status port; datapath and timing are identical.
// TESTING
//  1) 1.0+1.0: exp_a1=127, ma=mb=24'h800000, signs 0, s1=0 -> result 32'h40000000, out_valid at T+2.
//  2) 1.0-0.75: exp_a1=127, ma=24'h800000, mb=24'h600000, s1=1 -> 32'h3E800000, out_valid at T+4 (2 shifts).
//  3) 1.0-1.0: ma=mb=24'h800000, s1=1 -> 32'h00000000, zero flag=1 (with FPADD_STATUS_EN), latency 2.
//  4) Overflow: exp_a1=254, ma=mb=24'hFFFFFF, s1=0 -> 32'h7F800000, overflow flag=1.
//  5) Backpressure: out_ready=0 for 5 cycles after out_valid.
//     -> result stable, in_ready=0, a new in_valid is not accepted until the handshake completes.
//  6) Reset mid-NORM: rst_n=0 for 1 edge during case 2 -> out_valid=0, result=0, in_ready=1.
//     -> Next operand is processed correctly.

Source files
------------

// File: rtl/fp_add_step2_addnorm.sv
// Stage 2 of the pipelined FP adder: mantissa add/sub, iterative normalise, pack.
// Optional FPADD_STATUS_EN adds status[2:0] = {overflow, underflow, zero}.
module fp_add_step2_addnorm #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_a1,
  input  logic             sign_b1,
  input  logic             s1,
  input  logic [EXP_W-1:0] exp_a1,
  input  logic [EXP_W-1:0] exp_b1,
  input  logic [MAN_W-1:0] mantissa_a1,
  input  logic [MAN_W-1:0] mantissa_b1,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef FPADD_STATUS_EN
  output logic [2:0]       status,
`endif
  output logic [31:0]      result
);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    NORM,
    DONE
  } state_t;

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  state_t           state;
  logic             sa_q;
  logic             sb_q;
  logic             s1_q;
  logic [EXP_W-1:0] exp_q;
  logic [MAN_W-1:0] ma_q;
  logic [MAN_W-1:0] mb_q;
  logic [MAN_W:0]   sum_q;
  logic             sign_q;
  logic             ovf_q;
  logic             unf_q;
  logic             zero_q;

  logic             eff_sub;
  logic [MAN_W:0]   add_sum;
  logic             add_sign;
  logic [EXP_W:0]   exp_inc;

  logic             unused_exp_b;
  assign unused_exp_b = ^exp_b1;

  assign eff_sub = sa_q ^ sb_q ^ s1_q;
  assign exp_inc = {1'b0, exp_q} + (EXP_W + 1)'(1);

  always_comb begin
    add_sum  = {1'b0, ma_q} + {1'b0, mb_q};
    add_sign = sa_q;
    if (eff_sub) begin
      if (ma_q >= mb_q) begin
        add_sum = {1'b0, ma_q} - {1'b0, mb_q};
      end else begin
        add_sum  = {1'b0, mb_q} - {1'b0, ma_q};
        add_sign = sb_q ^ s1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      s1_q      <= 1'b0;
      exp_q     <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      sum_q     <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      zero_q    <= 1'b0;
`ifdef FPADD_STATUS_EN
      status    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sa_q     <= sign_a1;
            sb_q     <= sign_b1;
            s1_q     <= s1;
            exp_q    <= exp_a1;
            ma_q     <= mantissa_a1;
            mb_q     <= mantissa_b1;
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end
        ADD: begin
          sign_q <= add_sign;
          if (add_sum == '0) begin
            sum_q  <= '0;
            exp_q  <= '0;
            sign_q <= 1'b0;
            zero_q <= 1'b1;
            state  <= DONE;
          end else if (add_sum[MAN_W]) begin
            state <= DONE;
            if (exp_inc[EXP_W-1:0] == EXP_MAX) begin
              sum_q <= '0;
              exp_q <= EXP_MAX;
              ovf_q <= 1'b1;
            end else begin
              sum_q <= add_sum >> 1;
              exp_q <= exp_inc[EXP_W-1:0];
            end
          end else begin
            sum_q <= add_sum;
            state <= add_sum[MAN_W-1] ? DONE : NORM;
          end
        end
        NORM: begin
          if (sum_q[MAN_W-1]) begin
            state <= DONE;
          end else if (exp_q > EXP_ONE) begin
            sum_q <= sum_q << 1;
            exp_q <= exp_q - EXP_ONE;
            // Look ahead so the final shift lands directly in DONE.
            if (sum_q[MAN_W-2]) state <= DONE;
          end else begin
            sum_q  <= '0;
            exp_q  <= '0;
            sign_q <= 1'b0;
            unf_q  <= 1'b1;
            zero_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            result    <= {sign_q, exp_q, sum_q[MAN_W-2:0]};
`ifdef FPADD_STATUS_EN
            status    <= {ovf_q, unf_q, zero_q};
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            zero_q    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_step2_addnorm.sv
// Randomised bench for fp_add_step2_addnorm against an arithmetic model.
// Status checks compile in when FPADD_STATUS_EN is defined.
module tb_fp_add_step2_addnorm;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic        sign_a1 = 0;
  logic        sign_b1 = 0;
  logic        s1 = 0;
  logic [7:0]  exp_a1 = 0;
  logic [7:0]  exp_b1 = 0;
  logic [23:0] mantissa_a1 = 0;
  logic [23:0] mantissa_b1 = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] result;
`ifdef FPADD_STATUS_EN
  logic [2:0]  status;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_add_step2_addnorm dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sign_a1(sign_a1),
    .sign_b1(sign_b1),
    .s1(s1),
    .exp_a1(exp_a1),
    .exp_b1(exp_b1),
    .mantissa_a1(mantissa_a1),
    .mantissa_b1(mantissa_b1),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef FPADD_STATUS_EN
    .status(status),
`endif
    .result(result)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Plain-arithmetic reference: exact sum, leading-one search, truncation.
  function automatic void model(input bit sa, input bit sb, input bit op,
                                input int e, input longint ma,
                                input longint mb,
                                output logic [31:0] r, output int k,
                                output logic [2:0] st);
    longint s;
    bit sg;
    int p;
    k = 0;
    st = 3'b000;
    sg = sa;
    if ((sa ^ sb ^ op) == 0) s = ma + mb;
    else if (ma >= mb) s = ma - mb;
    else begin
      s = mb - ma;
      sg = sb ^ op;
    end
    if (s == 0) begin
      r = 32'h0;
      st = 3'b001;
    end else if (s >= 64'd16777216) begin
      s = s / 2;
      e = e + 1;
      if (e == 255) begin
        r = {sg, 8'hFF, 23'h0};
        st = 3'b100;
      end else begin
        r = {sg, 8'(e), 23'(s)};
      end
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (s >= (64'd1 << i)) p = i;
      k = 23 - p;
      if (e - k >= 1) begin
        s = s * (64'd1 << k);
        r = {sg, 8'(e - k), 23'(s)};
      end else begin
        r = 32'h0;
        st = 3'b011;
      end
    end
  endfunction

  task automatic run_op(input string tag, input bit sa, input bit sb,
                        input bit op, input logic [7:0] e,
                        input logic [23:0] ma, input logic [23:0] mb,
                        input int hold);
    logic [31:0] r;
    int k;
    int n;
    logic [2:0] st;
    model(sa, sb, op, int'(e), longint'(ma), longint'(mb), r, k, st);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_inrdy"}, {31'h0, in_ready}, 32'h1);
    sign_a1 = sa;
    sign_b1 = sb;
    s1 = op;
    exp_a1 = e;
    exp_b1 = 8'($urandom);
    mantissa_a1 = ma;
    mantissa_b1 = mb;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    chk({tag, "_res"}, result, r);
    if (st[1] == 1'b0) chk({tag, "_lat"}, 32'(n), 32'(2 + k));
`ifdef FPADD_STATUS_EN
    chk({tag, "_stat"}, {29'h0, status}, {29'h0, st});
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1;
      mantissa_a1 = 24'($urandom);
      @(posedge clk);
      #1;
      chk({tag, "_hold_res"}, result, r);
      chk({tag, "_hold_rdy"}, {31'h0, in_ready}, 32'h0);
      chk({tag, "_hold_vld"}, {31'h0, out_valid}, 32'h1);
    end
    @(negedge clk);
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk({tag, "_hs_vld"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_hs_rdy"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    logic [23:0] ma;
    logic [23:0] mb;
    logic [7:0] e;
    int sel;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inrdy", {31'h0, in_ready}, 32'h1);
    chk("rst_vld", {31'h0, out_valid}, 32'h0);
    chk("rst_res", result, 32'h0);
    @(negedge clk);
    rst_n = 1;

    run_op("one_plus_one", 0, 0, 0, 8'd127, 24'h800000, 24'h800000, 0);
    run_op("one_minus_q", 0, 0, 1, 8'd127, 24'h800000, 24'h600000, 0);
    run_op("cancel", 0, 0, 1, 8'd127, 24'h800000, 24'h800000, 0);
    run_op("ovf", 0, 0, 0, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 0);
    run_op("bkp", 1, 0, 1, 8'd100, 24'hC00000, 24'h200000, 5);
    run_op("neg_res", 0, 0, 1, 8'd127, 24'h600000, 24'h800000, 0);
    run_op("unf", 0, 1, 0, 8'd3, 24'h800000, 24'h7FFFFF, 0);

    // Abort case 2 partway through normalisation.
    @(negedge clk);
    sign_a1 = 0;
    sign_b1 = 0;
    s1 = 1;
    exp_a1 = 8'd127;
    mantissa_a1 = 24'h800000;
    mantissa_b1 = 24'h600000;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("midrst_vld", {31'h0, out_valid}, 32'h0);
    chk("midrst_res", result, 32'h0);
    chk("midrst_rdy", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1;
    run_op("after_rst", 0, 0, 1, 8'd127, 24'h800000, 24'h600000, 0);

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      e = 8'($urandom_range(1, 254));
      if (sel == 0) e = 8'($urandom_range(1, 24));
      if (sel == 1) e = 8'd254;
      ma = 24'h800000 | 24'($urandom);
      mb = (24'h800000 | 24'($urandom)) >> $urandom_range(0, 25);
      if (sel == 2) mb = ma ^ 24'($urandom_range(0, 255));
      if (sel == 3) mb = ma;
      run_op("rnd", 1'($urandom), 1'($urandom), 1'($urandom), e, ma, mb,
             $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
